// File: rtl/operand_checker.sv
// Monitor stage that recomputes the golden result from the delayed driver operands,
// aligns it to the DUT latency and scores a fixed-length run against the DUT output.
module operand_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DUT_LATENCY = 1,
  parameter int unsigned OP          = 0,
  parameter int unsigned NUM_SAMPLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_drive_delayed_a,
  input  logic [WIDTH-1:0] i_drive_delayed_b,
  input  logic [WIDTH-1:0] i_dut_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [15:0]      o_err_count,
  output logic [31:0]      o_sample_count,
  output logic [WIDTH-1:0] o_fail_a,
  output logic [WIDTH-1:0] o_fail_b,
  output logic [WIDTH-1:0] o_fail_expected,
  output logic [WIDTH-1:0] o_fail_actual
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [31:0]      r_cap_cnt;
  logic [3:0]       r_drain_cnt;
  logic             w_start_acc;
  logic             w_cap_en;
  logic             w_last_cap;
  logic             w_last_drain;
  logic [WIDTH-1:0] w_golden;
  logic             w_cmp_valid;
  logic [WIDTH-1:0] w_cmp_a;
  logic [WIDTH-1:0] w_cmp_b;
  logic [WIDTH-1:0] w_cmp_exp;
  logic             w_mismatch;
  logic [15:0]      r_err_count;
  logic [31:0]      r_sample_count;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [WIDTH-1:0] r_fail_expected;
  logic [WIDTH-1:0] r_fail_actual;

  assign w_start_acc  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_cap_en     = (r_state == ST_RUN);
  assign w_last_cap   = w_cap_en && (r_cap_cnt == NUM_SAMPLES - 1);
  assign w_last_drain = (r_state == ST_DRAIN) &&
                        (({28'd0, r_drain_cnt} + 32'd1) == DUT_LATENCY);

  always_comb begin
    w_golden = i_drive_delayed_a + i_drive_delayed_b;
    if (OP == 1) begin
      w_golden = i_drive_delayed_a - i_drive_delayed_b;
    end else if (OP == 2) begin
      w_golden = i_drive_delayed_a * i_drive_delayed_b;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start) w_state_next = ST_RUN;
      ST_RUN:   if (w_last_cap) w_state_next = (DUT_LATENCY == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (w_last_drain) w_state_next = ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cap_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_acc) begin
        r_cap_cnt <= '0;
      end else if (w_cap_en) begin
        r_cap_cnt <= r_cap_cnt + 32'd1;
      end
      // Held at zero through RUN so DRAIN always starts counting from 0.
      if (w_cap_en) begin
        r_drain_cnt <= '0;
      end else if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 4'd1;
      end
    end
  end

  if (DUT_LATENCY == 0) begin : g_no_pipe
    assign w_cmp_valid = w_cap_en;
    assign w_cmp_a     = i_drive_delayed_a;
    assign w_cmp_b     = i_drive_delayed_b;
    assign w_cmp_exp   = w_golden;
  end else begin : g_pipe
    logic [DUT_LATENCY-1:0] r_pipe_v;
    logic [WIDTH-1:0]       r_pipe_a   [DUT_LATENCY];
    logic [WIDTH-1:0]       r_pipe_b   [DUT_LATENCY];
    logic [WIDTH-1:0]       r_pipe_exp [DUT_LATENCY];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_pipe_v <= '0;
        for (int i = 0; i < DUT_LATENCY; i++) begin
          r_pipe_a[i]   <= '0;
          r_pipe_b[i]   <= '0;
          r_pipe_exp[i] <= '0;
        end
      end else begin
        if (w_start_acc) begin
          r_pipe_v <= '0;
        end else begin
          r_pipe_v[0] <= w_cap_en;
          for (int i = 1; i < DUT_LATENCY; i++) begin
            r_pipe_v[i] <= r_pipe_v[i-1];
          end
        end
        r_pipe_a[0]   <= i_drive_delayed_a;
        r_pipe_b[0]   <= i_drive_delayed_b;
        r_pipe_exp[0] <= w_golden;
        for (int i = 1; i < DUT_LATENCY; i++) begin
          r_pipe_a[i]   <= r_pipe_a[i-1];
          r_pipe_b[i]   <= r_pipe_b[i-1];
          r_pipe_exp[i] <= r_pipe_exp[i-1];
        end
      end
    end

    assign w_cmp_valid = r_pipe_v[DUT_LATENCY-1];
    assign w_cmp_a     = r_pipe_a[DUT_LATENCY-1];
    assign w_cmp_b     = r_pipe_b[DUT_LATENCY-1];
    assign w_cmp_exp   = r_pipe_exp[DUT_LATENCY-1];
  end

  assign w_mismatch = w_cmp_valid && (w_cmp_exp != i_dut_result);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count     <= '0;
      r_sample_count  <= '0;
      r_fail_a        <= '0;
      r_fail_b        <= '0;
      r_fail_expected <= '0;
      r_fail_actual   <= '0;
    end else if (w_start_acc) begin
      r_err_count     <= '0;
      r_sample_count  <= '0;
      r_fail_a        <= '0;
      r_fail_b        <= '0;
      r_fail_expected <= '0;
      r_fail_actual   <= '0;
    end else if (w_cmp_valid) begin
      r_sample_count <= r_sample_count + 32'd1;
      if (w_mismatch) begin
        if (r_err_count != 16'hFFFF) begin
          r_err_count <= r_err_count + 16'd1;
        end
        // A saturated count never returns to zero, so zero marks the first mismatch.
        if (r_err_count == 16'd0) begin
          r_fail_a        <= w_cmp_a;
          r_fail_b        <= w_cmp_b;
          r_fail_expected <= w_cmp_exp;
          r_fail_actual   <= i_dut_result;
        end
      end
    end
  end

  assign o_busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done          = (r_state == ST_DONE);
  assign o_pass          = o_done && (r_err_count == 16'd0);
  assign o_err_count     = r_err_count;
  assign o_sample_count  = r_sample_count;
  assign o_fail_a        = r_fail_a;
  assign o_fail_b        = r_fail_b;
  assign o_fail_expected = r_fail_expected;
  assign o_fail_actual   = r_fail_actual;

endmodule

// File: tb/tb_operand_checker.sv
// Bench for operand_checker: four configurations share stimulus and are scored every
// cycle against a run-timeline model, plus hand-computed checks from the test plan.
module tb_operand_checker;

  localparam int NI = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_a  = '0;
  logic [31:0] in_b  = '0;
  logic [31:0] res   [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        pass  [NI];
  logic [15:0] errc  [NI];
  logic [31:0] sampc [NI];
  logic [31:0] fa    [NI];
  logic [31:0] fb    [NI];
  logic [31:0] fe    [NI];
  logic [31:0] fact  [NI];

  int unsigned m_op  [NI];
  int unsigned m_lat [NI];
  int unsigned m_n   [NI];

  always #5 clk = ~clk;

  operand_checker #(.WIDTH(32), .DUT_LATENCY(1), .OP(0), .NUM_SAMPLES(16)) u_add (
    .clk(clk), .reset(reset), .i_start(start), .i_drive_delayed_a(in_a),
    .i_drive_delayed_b(in_b), .i_dut_result(res[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_pass(pass[0]), .o_err_count(errc[0]), .o_sample_count(sampc[0]), .o_fail_a(fa[0]),
    .o_fail_b(fb[0]), .o_fail_expected(fe[0]), .o_fail_actual(fact[0])
  );

  operand_checker #(.WIDTH(32), .DUT_LATENCY(0), .OP(1), .NUM_SAMPLES(4)) u_sub (
    .clk(clk), .reset(reset), .i_start(start), .i_drive_delayed_a(in_a),
    .i_drive_delayed_b(in_b), .i_dut_result(res[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_pass(pass[1]), .o_err_count(errc[1]), .o_sample_count(sampc[1]), .o_fail_a(fa[1]),
    .o_fail_b(fb[1]), .o_fail_expected(fe[1]), .o_fail_actual(fact[1])
  );

  operand_checker #(.WIDTH(32), .DUT_LATENCY(2), .OP(0), .NUM_SAMPLES(65540)) u_sat (
    .clk(clk), .reset(reset), .i_start(start), .i_drive_delayed_a(in_a),
    .i_drive_delayed_b(in_b), .i_dut_result(res[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_pass(pass[2]), .o_err_count(errc[2]), .o_sample_count(sampc[2]), .o_fail_a(fa[2]),
    .o_fail_b(fb[2]), .o_fail_expected(fe[2]), .o_fail_actual(fact[2])
  );

  operand_checker #(.WIDTH(32), .DUT_LATENCY(3), .OP(2), .NUM_SAMPLES(20)) u_mul (
    .clk(clk), .reset(reset), .i_start(start), .i_drive_delayed_a(in_a),
    .i_drive_delayed_b(in_b), .i_dut_result(res[3]), .o_busy(busy[3]), .o_done(done[3]),
    .o_pass(pass[3]), .o_err_count(errc[3]), .o_sample_count(sampc[3]), .o_fail_a(fa[3]),
    .o_fail_b(fb[3]), .o_fail_expected(fe[3]), .o_fail_actual(fact[3])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [178:0] act, input logic [178:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 100) $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, {147'd0, act}, {147'd0, exp});
  endtask

  function automatic logic [31:0] gold(input int unsigned op, input logic [31:0] a,
                                       input logic [31:0] b);
    case (op)
      1:       return a - b;
      2:       return a * b;
      default: return a + b;
    endcase
  endfunction

  // Model: a run is a timeline t = 0,1,... counted from the start edge.
  bit          m_run  [NI];
  bit          m_done [NI];
  int unsigned m_t    [NI];
  logic [15:0] m_err  [NI];
  logic [31:0] m_samp [NI];
  logic [31:0] m_fa   [NI];
  logic [31:0] m_fb   [NI];
  logic [31:0] m_fe   [NI];
  logic [31:0] m_fact [NI];
  logic [31:0] h_a    [NI][16];
  logic [31:0] h_b    [NI][16];
  logic [31:0] h_e    [NI][16];

  always @(posedge clk or negedge reset) begin
    int unsigned k;
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_run[i] = 1'b0; m_done[i] = 1'b0; m_t[i] = 0; m_err[i] = '0; m_samp[i] = '0;
        m_fa[i] = '0; m_fb[i] = '0; m_fe[i] = '0; m_fact[i] = '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (!m_run[i]) begin
          if (start) begin
            m_run[i] = 1'b1; m_done[i] = 1'b0; m_t[i] = 0; m_err[i] = '0; m_samp[i] = '0;
            m_fa[i] = '0; m_fb[i] = '0; m_fe[i] = '0; m_fact[i] = '0;
          end
        end else begin
          if (m_t[i] < m_n[i]) begin
            h_a[i][m_t[i] % 16] = in_a;
            h_b[i][m_t[i] % 16] = in_b;
            h_e[i][m_t[i] % 16] = gold(m_op[i], in_a, in_b);
          end
          if (m_t[i] >= m_lat[i]) begin
            k = (m_t[i] - m_lat[i]) % 16;
            m_samp[i] = m_samp[i] + 1;
            if (res[i] != h_e[i][k]) begin
              if (m_err[i] == 16'd0) begin
                m_fa[i] = h_a[i][k]; m_fb[i] = h_b[i][k];
                m_fe[i] = h_e[i][k]; m_fact[i] = res[i];
              end
              if (m_err[i] != 16'hFFFF) m_err[i] = m_err[i] + 16'd1;
            end
          end
          m_t[i] = m_t[i] + 1;
          if (m_t[i] == m_n[i] + m_lat[i]) begin
            m_run[i]  = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [178:0] dut_vec(input int i);
    return {busy[i], done[i], pass[i], errc[i], sampc[i], fa[i], fb[i], fe[i], fact[i]};
  endfunction

  function automatic logic [178:0] model_vec(input int i);
    return {m_run[i], m_done[i], m_done[i] && (m_err[i] == 16'd0), m_err[i], m_samp[i],
            m_fa[i], m_fb[i], m_fe[i], m_fact[i]};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) check($sformatf("u%0d outputs", i), dut_vec(i), model_vec(i));
  end

  // Stimulus: a behavioural DUT per instance that echoes the golden result L cycles late.
  int unsigned cyc = 0;
  logic [31:0] ga   [16];
  logic [31:0] gb   [16];
  logic [31:0] flip [NI];
  logic [31:0] lf   = 32'h1234_5678;

  function automatic logic [31:0] lfsr(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'hA300_0000 : 32'h0);
  endfunction

  task automatic rand_pair(output logic [31:0] x, output logic [31:0] y);
    lf = lfsr(lf); x = lf;
    lf = lfsr(lf); y = lf;
  endtask

  task automatic cycle(input logic [31:0] na, input logic [31:0] nb, input logic st);
    int unsigned idx;
    in_a = na; in_b = nb; start = st;
    ga[cyc % 16] = na;
    gb[cyc % 16] = nb;
    for (int i = 0; i < NI; i++) begin
      idx = (cyc - m_lat[i]) % 16;
      res[i] = gold(m_op[i], ga[idx], gb[idx]) ^ flip[i];
    end
    res[2] = '0;
    @(negedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] x, y, sat_a, sat_b;
    int n;
    m_op  = '{0, 1, 0, 2};
    m_lat = '{1, 0, 2, 3};
    m_n   = '{16, 4, 65540, 20};
    for (int i = 0; i < NI; i++) flip[i] = '0;
    for (int i = 0; i < 16; i++) begin ga[i] = '0; gb[i] = '0; end
    sat_a = '0; sat_b = '0;

    repeat (3) cycle(32'h0, 32'h0, 1'b0);
    check("reset outputs zero", dut_vec(0), 179'd0);
    reset = 1'b1;
    cycle(32'h0, 32'h0, 1'b0);

    // Abandon a run with reset, then rerun cleanly.
    rand_pair(x, y); cycle(x, y, 1'b1);
    repeat (8) begin rand_pair(x, y); cycle(x, y, 1'b0); end
    chk("busy mid-run", {31'd0, busy[0]}, 32'd1);
    reset = 1'b0;
    #1;
    check("outputs zero at reset", dut_vec(0), 179'd0);
    repeat (2) begin rand_pair(x, y); cycle(x, y, 1'b0); end
    reset = 1'b1;
    cycle(32'h0, 32'h0, 1'b0);

    // Clean adder run; u_sat starts its long run here too.
    rand_pair(x, y); cycle(x, y, 1'b1);
    n = 0;
    for (int j = 1; j <= 40; j++) begin
      rand_pair(x, y);
      if (j == 1) begin sat_a = x; sat_b = y; end
      cycle(x, y, 1'b0);
      if (done[0]) begin n = j; break; end
    end
    chk("add done latency", n, 32'd17);
    chk("add samples", sampc[0], 32'd16);
    chk("add errors", {16'd0, errc[0]}, 32'd0);
    chk("add pass", {31'd0, pass[0]}, 32'd1);
    chk("add fail regs", fa[0] | fb[0] | fe[0] | fact[0], 32'd0);

    // Restart from DONE with sample 5 corrupted; starts in RUN and DRAIN are ignored.
    n = 0;
    for (int j = 0; j <= 40; j++) begin
      rand_pair(x, y);
      if (j == 6) begin x = 32'd3; y = 32'd4; end
      flip[0] = (j == 7) ? 32'd1 : 32'd0;
      cycle(x, y, (j == 0) || (j == 3) || (j == 17));
      if (j == 0) begin
        chk("restart clears done", {31'd0, done[0]}, 32'd0);
        chk("restart clears samples", sampc[0], 32'd0);
      end
      if (j > 0 && done[0]) begin n = j; break; end
    end
    flip[0] = '0;
    chk("corrupt done latency", n, 32'd17);
    chk("corrupt errors", {16'd0, errc[0]}, 32'd1);
    chk("corrupt pass", {31'd0, pass[0]}, 32'd0);
    chk("corrupt fail_a", fa[0], 32'd3);
    chk("corrupt fail_b", fb[0], 32'd4);
    chk("corrupt fail_expected", fe[0], 32'd7);
    chk("corrupt fail_actual", fact[0], 32'd6);

    // Subtract with zero latency: 0 - 1 wraps to all ones.
    repeat (6) begin rand_pair(x, y); cycle(x, y, 1'b0); end
    cycle(32'd0, 32'd1, 1'b1);
    n = 0;
    for (int j = 1; j <= 20; j++) begin
      cycle(32'd0, 32'd1, 1'b0);
      if (done[1]) begin n = j; break; end
    end
    chk("sub done latency", n, 32'd4);
    chk("sub samples", sampc[1], 32'd4);
    chk("sub errors", {16'd0, errc[1]}, 32'd0);
    chk("sub pass", {31'd0, pass[1]}, 32'd1);

    // Random operands, random start pulses and sparse single-bit result corruption.
    for (int j = 0; j < 400; j++) begin
      x = $urandom; y = $urandom;
      for (int i = 0; i < NI; i++)
        flip[i] = ($urandom_range(0, 9) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
      cycle(x, y, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < NI; i++) flip[i] = '0;

    // Wait out the saturating run.
    n = 0;
    for (int j = 0; j < 70000; j++) begin
      x = $urandom | 32'd1; y = $urandom;
      cycle(x, y, 1'b0);
      if (done[2]) begin n = 1; break; end
    end
    chk("sat run completes", n, 32'd1);
    chk("sat errors", {16'd0, errc[2]}, 32'h0000_FFFF);
    chk("sat samples", sampc[2], 32'd65540);
    chk("sat pass", {31'd0, pass[2]}, 32'd0);
    chk("sat fail_a", fa[2], sat_a);
    chk("sat fail_b", fb[2], sat_b);
    chk("sat fail_expected", fe[2], sat_a + sat_b);
    chk("sat fail_actual", fact[2], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
